// File: rtl/decode_stage_pkg.sv
// Decode constants shared by the decode stage: opcodes, R-type functs, opcode classes,
// immediate extension modes and the layout of one decoded buffer entry.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_JUMP, CLS_LINK, CLS_BRANCH, CLS_ARITH,
    CLS_LOGIC, CLS_UPPER, CLS_LOAD, CLS_STORE, CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_UPPER} imm_mode_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        reg_write;
    logic        illegal;
    logic [31:0] jtarget;
  } dec_t;

  function automatic op_class_e op_class(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE:              return CLS_RTYPE;
      OP_J:                  return CLS_JUMP;
      OP_JAL:                return CLS_LINK;
      OP_BEQ, OP_BNE:        return CLS_BRANCH;
      OP_ADDI:               return CLS_ARITH;
      OP_ANDI, OP_ORI, OP_XORI: return CLS_LOGIC;
      OP_LUI:                return CLS_UPPER;
      OP_LW:                 return CLS_LOAD;
      OP_SW:                 return CLS_STORE;
      default:               return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_extend.sv
// Widens a 16-bit instruction immediate to IMM_WIDTH: sign-extend, zero-extend, or place in
// the upper half of a 32-bit word (then truncated/zero-padded). Purely combinational.
module imm_extend
  import decode_pkg::*;
#(
  parameter int IMM_WIDTH = 32
) (
  input  logic [15:0]          i_imm,
  input  imm_mode_e            i_mode,
  output logic [IMM_WIDTH-1:0] o_imm
);

  always_comb begin
    o_imm = IMM_WIDTH'(i_imm);
    case (i_mode)
      IMM_SIGN:  o_imm = IMM_WIDTH'($signed(i_imm));
      IMM_ZERO:  o_imm = IMM_WIDTH'(i_imm);
      IMM_UPPER: o_imm = IMM_WIDTH'({i_imm, 16'h0000});
      default:   o_imm = IMM_WIDTH'(i_imm);
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: one-cycle latency from accept to out_*, valid/ready on both sides,
// 2-entry skid buffer (SKID=1, in_ready registered) or single output register (SKID=0).
module decode_stage
  import decode_pkg::*;
#(
  parameter int IMM_WIDTH = 32,
  parameter int LINK_REG  = 31,
  parameter int SKID      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_opcode,
  output logic [5:0]           out_funct,
  output logic [4:0]           out_rs,
  output logic [4:0]           out_rt,
  output logic [4:0]           out_shamt,
  output logic [4:0]           out_dest,
  output logic                 out_reg_write,
  output logic [IMM_WIDTH-1:0] out_imm,
  output logic [31:0]          out_jtarget,
  output logic                 out_illegal
);

  dec_t                 w_dec;
  imm_mode_e            w_mode;
  logic [IMM_WIDTH-1:0] w_imm;
  logic                 w_accept;
  logic                 w_slot_free;

  dec_t                 r_out;
  dec_t                 r_skid;
  logic [IMM_WIDTH-1:0] r_out_imm;
  logic [IMM_WIDTH-1:0] r_skid_imm;
  logic                 r_out_vld;
  logic                 r_skid_vld;

  always_comb begin
    w_dec           = '0;
    w_mode          = IMM_SIGN;
    w_dec.opcode    = in_instr[31:26];
    w_dec.funct     = in_instr[5:0];
    w_dec.rs        = in_instr[25:21];
    w_dec.rt        = in_instr[20:16];
    w_dec.shamt     = in_instr[10:6];
    w_dec.dest      = in_instr[20:16];
    w_dec.jtarget   = {4'((in_pc + 32'd4) >> 28), in_instr[25:0], 2'b00};
    case (op_class(in_instr[31:26]))
      CLS_RTYPE: begin
        w_dec.dest = in_instr[15:11];
        case (in_instr[5:0])
          FN_ADD, FN_SUB, FN_SLT: w_dec.reg_write = 1'b1;
          FN_JR:                  w_dec.reg_write = 1'b0;
          default:                w_dec.illegal   = 1'b1;
        endcase
      end
      CLS_LINK: begin
        w_dec.dest      = 5'(LINK_REG);
        w_dec.reg_write = 1'b1;
      end
      CLS_ARITH, CLS_LOAD: w_dec.reg_write = 1'b1;
      CLS_LOGIC: begin
        w_dec.reg_write = 1'b1;
        w_mode          = IMM_ZERO;
      end
      CLS_UPPER: begin
        w_dec.reg_write = 1'b1;
        w_mode          = IMM_UPPER;
      end
      CLS_ILLEGAL: w_dec.illegal = 1'b1;
      default:     w_dec.reg_write = 1'b0;
    endcase
  end

  imm_extend #(.IMM_WIDTH(IMM_WIDTH)) u_imm_extend (
    .i_imm  (in_instr[15:0]),
    .i_mode (w_mode),
    .o_imm  (w_imm)
  );

  // The output slot can take a new word this edge if it is empty or being drained.
  assign w_slot_free = !r_out_vld || out_ready;
  assign in_ready    = (SKID != 0) ? !r_skid_vld : w_slot_free;
  assign w_accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_imm  <= '0;
      r_skid_imm <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_slot_free) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_imm  <= r_skid_imm;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_accept) begin
        r_out     <= w_dec;
        r_out_imm <= w_imm;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid     <= w_dec;
      r_skid_imm <= w_imm;
      r_skid_vld <= 1'b1;
    end
  end

  assign out_valid     = r_out_vld;
  assign out_opcode    = r_out.opcode;
  assign out_funct     = r_out.funct;
  assign out_rs        = r_out.rs;
  assign out_rt        = r_out.rt;
  assign out_shamt     = r_out.shamt;
  assign out_dest      = r_out.dest;
  assign out_reg_write = r_out.reg_write;
  assign out_illegal   = r_out.illegal;
  assign out_jtarget   = r_out.jtarget;
  assign out_imm       = r_out_imm;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction vectors with hand-computed results.
`timescale 1ns/1ps
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_shamt, out_dest;
  logic        out_reg_write, out_illegal;
  logic [31:0] out_imm, out_jtarget;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        rw;
    logic [31:0] imm;
    logic [31:0] jt;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t mon_v;

  always #5 clk = ~clk;

  decode_stage #(.IMM_WIDTH(32), .LINK_REG(31), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs), .out_rt(out_rt),
    .out_shamt(out_shamt), .out_dest(out_dest), .out_reg_write(out_reg_write),
    .out_imm(out_imm), .out_jtarget(out_jtarget), .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] dest,
                         input logic rw, input logic [31:0] imm, input logic [31:0] jt,
                         input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.dest = dest; v.rw = rw; v.imm = imm; v.jt = jt; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input int idx);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_pc    = vecs[idx].pc;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
    end else begin
      exp_q.push_back(vecs[idx]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer is compared against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got opcode 0x%02h dest %0d, expected no output",
                   out_opcode, out_dest);
        end else begin
          mon_v = exp_q.pop_front();
          chk("opcode",    32'(out_opcode),    32'(mon_v.instr[31:26]));
          chk("funct",     32'(out_funct),     32'(mon_v.instr[5:0]));
          chk("rs",        32'(out_rs),        32'(mon_v.instr[25:21]));
          chk("rt",        32'(out_rt),        32'(mon_v.instr[20:16]));
          chk("shamt",     32'(out_shamt),     32'(mon_v.instr[10:6]));
          chk("dest",      32'(out_dest),      32'(mon_v.dest));
          chk("reg_write", 32'(out_reg_write), 32'(mon_v.rw));
          chk("imm",       out_imm,            mon_v.imm);
          chk("jtarget",   out_jtarget,        mon_v.jt);
          chk("illegal",   32'(out_illegal),   32'(mon_v.ill));
        end
      end
    end
  end

  initial begin
    //        instr         pc            dest rw imm           jtarget       ill
    add_vec(32'h2128FFFF, 32'h00001000, 5'd8,  1, 32'hFFFFFFFF, 32'h04A3FFFC, 0); // 0 addi
    add_vec(32'h0C000010, 32'h00400000, 5'd31, 1, 32'h00000010, 32'h00000040, 0); // 1 jal
    add_vec(32'h34088000, 32'h00001004, 5'd8,  1, 32'h00008000, 32'h00220000, 0); // 2 ori
    add_vec(32'h3C091234, 32'h00001008, 5'd9,  1, 32'h12340000, 32'h002448D0, 0); // 3 lui
    add_vec(32'h8FAAFFFC, 32'hF000000C, 5'd10, 1, 32'hFFFFFFFC, 32'hFEABFFF0, 0); // 4 lw
    add_vec(32'hFC001234, 32'h00002000, 5'd0,  0, 32'h00001234, 32'h000048D0, 1); // 5 op 3F
    add_vec(32'h00221801, 32'h00002004, 5'd3,  0, 32'h00001801, 32'h00886004, 1); // 6 funct 01
    add_vec(32'h00221820, 32'h00002008, 5'd3,  1, 32'h00001820, 32'h00886080, 0); // 7 add
    add_vec(32'h00222022, 32'h0000200C, 5'd4,  1, 32'h00002022, 32'h00888088, 0); // 8 sub
    add_vec(32'h03E00008, 32'h00002010, 5'd0,  0, 32'h00000008, 32'h0F800020, 0); // 9 jr
    add_vec(32'h1022FFFE, 32'h00002014, 5'd2,  0, 32'hFFFFFFFE, 32'h008BFFF8, 0); // 10 beq
    add_vec(32'hAC850008, 32'h00002018, 5'd5,  0, 32'h00000008, 32'h02140020, 0); // 11 sw
    add_vec(32'h0022282A, 32'h0000201C, 5'd5,  1, 32'h0000282A, 32'h0088A0A8, 0); // 12 slt
    add_vec(32'h30E6FFFF, 32'h00002020, 5'd6,  1, 32'h0000FFFF, 32'h039BFFFC, 0); // 13 andi
    add_vec(32'h08000100, 32'h00002024, 5'd0,  0, 32'h00000100, 32'h00000400, 0); // 14 j
    add_vec(32'h0C000010, 32'h1FFFFFFC, 5'd31, 1, 32'h00000010, 32'h20000040, 0); // 15 jal, pc+4 carry

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_imm",       out_imm,        32'd0);
    chk("rst_dest",      32'(out_dest),  32'd0);
    chk("rst_jtarget",   out_jtarget,    32'd0);

    // Streaming with out_ready high, including one-cycle latency on the first word.
    out_ready = 1'b1;
    send(0);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_dest",      32'(out_dest),  32'd8);
    for (int i = 1; i <= 4; i++) send(i);
    for (int i = 7; i <= 15; i++) send(i);
    @(negedge clk);

    // Stall: two words sent while out_ready is low; the second waits in the skid entry.
    out_ready = 1'b0;
    send(5);
    send(6);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid",   32'(out_valid),   32'd1);
      chk("stall_opcode",  32'(out_opcode),  32'h3F);
      chk("stall_imm",     out_imm,          32'h00001234);
      chk("stall_illegal", 32'(out_illegal), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Flush with both entries full and a word presented.
    out_ready = 1'b0;
    send(0);
    send(2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_instr = vecs[3].instr; in_pc = vecs[3].pc; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);

    // Flush beats a same-cycle accept while in_ready is high.
    send(1);
    in_valid = 1'b1; in_instr = vecs[3].instr; in_pc = vecs[3].pc; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush2_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(4);
    @(negedge clk);

    // Reset mid-stream with both entries full.
    out_ready = 1'b0;
    send(8);
    send(9);
    in_valid = 1'b1; in_instr = vecs[10].instr; in_pc = vecs[10].pc; reset = 1'b1; flush = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    chk("mrst_imm",       out_imm,        32'd0);
    chk("mrst_dest",      32'(out_dest),  32'd0);
    out_ready = 1'b1;
    send(11);

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter IMM_WIDTH, default 32, width of the extended immediate output (minimum 16).
REQ-002 Parameter LINK_REG, default 31, destination register written by jal.
REQ-003 Parameter SKID, default 1; 1 gives a 2-entry skid buffer, 0 gives a single output register.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1, in_ready  output  1  upstream handshake.
REQ-008 in_instr  input  32  instruction word; in_pc  input  32  address of that instruction.
REQ-009 out_valid  output  1, out_ready  input  1  downstream handshake.
REQ-010 out_opcode  output  6, out_funct  output  6, out_rs  output  5, out_rt  output  5, out_shamt  output  5  raw fields.
REQ-011 out_dest  output  5  register-file write index; out_reg_write  output  1  write enable.
REQ-012 out_imm  output  IMM_WIDTH  extended immediate; out_jtarget  output  32  jump target.
REQ-013 out_illegal  output  1  unsupported opcode/funct flag.

Function
REQ-014 Transfers occur when valid and ready are both high on a clock edge; latency in_instr to out_* is exactly 1 cycle.
REQ-015 Supported opcodes: 0x00 R-type, 0x02 j, 0x03 jal, 0x04 beq, 0x05 bne, 0x08 addi, 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui, 0x23 lw, 0x2B sw; supported R-type funct: 0x20 add, 0x22 sub, 0x2A slt, 0x08 jr.
REQ-016 Immediate: andi/ori/xori zero-extend instr[15:0]; lui yields instr[15:0] in bits [31:16] with zeros below (truncated/zero-padded to IMM_WIDTH); all other opcodes, including lw and sw, sign-extend instr[15:0].
REQ-017 out_jtarget = {(in_pc+4)[31:28], instr[25:0], 2'b00} for every entry, regardless of opcode.
REQ-018 out_dest: R-type -> rd; jal -> LINK_REG; otherwise rt; out_rt always carries raw instr[20:16].
REQ-019 out_reg_write = 1 for add/sub/slt, addi, andi, ori, xori, lui, lw, jal; 0 for all others, including jr, j, beq, bne, sw, and illegal entries.
REQ-020 out_illegal = 1 for unsupported opcodes and for R-type with unsupported funct; illegal entries still pass through the handshake.
REQ-021 SKID=1: in_ready = skid entry empty (registered); when out_ready is low with out_valid high, an accepted word lands in the skid entry; when the output drains, the skid entry moves to the output on the next edge.
REQ-022 SKID=0: in_ready = !out_valid || out_ready.
REQ-023 While out_valid is high and out_ready is low, every out_* signal holds stable.
REQ-024 A simultaneous push and pop with both entries full is impossible, because in_ready is low; a simultaneous push and pop with one entry present replaces the output and leaves the skid entry empty.
REQ-025 flush clears both entries on the next edge and has priority over a same-cycle accept; the input word is dropped and in_ready is 1 after the flush.

Reset
REQ-026 On reset: out_valid=0, skid empty, in_ready=1 on the following cycle; all out_* data outputs are 0.
REQ-027 Reset mid-transfer discards all buffered entries; no partially decoded word survives reset.
REQ-028 Reset has priority over flush and over handshakes.

Structure
REQ-029 Shared package decode_pkg holds the opcode and funct localparams and the opcode-class decode constants.
REQ-030 One sub-module, imm_extend (combinational, IMM_WIDTH parameter, mode input: sign/zero/upper), computes the immediate.
REQ-031 Decode logic is combinational on in_instr and registers only at the buffer entries.

Verification
REQ-032 Stimulus: addi $t0,$t1,-1 (0x2128FFFF) with out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, out_dest=8, out_reg_write=1, out_illegal=0.
REQ-033 Stimulus: jal 0x0000010 at pc=0x00400000 -> out_dest=31, out_reg_write=1, out_jtarget=0x00000040.
REQ-034 Stimulus: ori 0x8000 -> out_imm=0x00008000; then lui 0x1234 -> out_imm=0x12340000; then lw offset 0xFFFC -> out_imm=0xFFFFFFFC.
REQ-035 Stimulus: stall with out_ready=0 for 3 cycles while 2 words are sent -> second word is held in the skid entry, in_ready=0, outputs stay stable, and both words emerge in order once out_ready=1.
REQ-036 Stimulus: flush asserted with in_valid=1 while both entries are full -> out_valid=0 next cycle, in_ready=1, and the dropped word never appears at the output.
REQ-037 Stimulus: opcode 0x3F, then R-type funct 0x01 -> out_illegal=1 and out_reg_write=0 for both words; reset asserted mid-stream -> out_valid=0 next cycle.
